// File: rtl/mest_pro_mm_ctrl_if.sv
// Memory request/response bus between the MESTPro execute unit (master)
// and the main-memory responder (slave).
interface mest_pro_mm_ctrl_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
);
    logic [ADDR_BITS-1:0] i_mm_addr;
    logic [DATA_BITS-1:0] i_mm_dat;
    logic                 i_mm_select;
    logic                 i_cs;
    logic                 i_we;
    logic [DATA_BITS-1:0] o_mm_rdata;
    logic                 o_mm_ready;
    logic                 o_busy;
    logic                 o_addr_err;

    modport master (
        output i_mm_addr, i_mm_dat, i_mm_select, i_cs, i_we,
        input  o_mm_rdata, o_mm_ready, o_busy, o_addr_err
    );

    modport slave (
        input  i_mm_addr, i_mm_dat, i_mm_select, i_cs, i_we,
        output o_mm_rdata, o_mm_ready, o_busy, o_addr_err
    );
endinterface

// File: rtl/mest_pro_mm_ctrl.sv
// Main-memory responder: captures one load/store request, waits WAIT_STATES
// cycles, then accesses an internal byte array and pulses ready for one cycle.
module mest_pro_mm_ctrl #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    i_reset,
    mest_pro_mm_ctrl_if.slave       mm
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] dat_q;
    logic                 we_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 busy_q;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 in_range_d;
    logic                 access_d;
    logic                 mem_we_d;
    logic [DATA_BITS-1:0] rdata_d;

    // Full-width compare: addresses at or beyond DEPTH never alias into the array.
    assign in_range_d = ({1'b0, addr_q} < DEPTH_L);
    assign access_d   = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign mem_we_d   = access_d && we_q && in_range_d;
    assign rdata_d    = in_range_d ? mem[addr_q[IDX_W-1:0]] : '0;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mm.i_mm_select && mm.i_cs) begin
                        addr_q  <= mm.i_mm_addr;
                        dat_q   <= mm.i_mm_dat;
                        we_q    <= mm.i_we;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= ACCESS;
                        busy_q  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= !in_range_d;
                        if (!we_q) begin
                            rdata_q <= rdata_d;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array has no reset so its contents survive i_reset; an abandoned access
    // never reaches here because reset forces the FSM back to IDLE.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[addr_q[IDX_W-1:0]] <= dat_q;
        end
    end

    always_ff @(posedge clk) begin
        assert (WAIT_STATES >= 0 && WAIT_STATES <= 15)
            else $error("WAIT_STATES out of range 0..15");
    end

    assign mm.o_mm_rdata = rdata_q;
    assign mm.o_mm_ready = ready_q;
    assign mm.o_busy     = busy_q;
    assign mm.o_addr_err = err_q;

endmodule
